// File: rtl/csr_regblock.sv
// csr_regblock: register block behind the APB4 bridge's internal register bus.
// Word map: RW control registers at 0..NUM_RW-1, live STATUS at NUM_RW,
// write-one-to-clear IRQ_PEND at NUM_RW+1; everything else answers with an error.
// Optional macro CSR_WAIT_EN inserts WAIT_CYCLES wait cycles before each response.
module csr_regblock #(
  parameter int unsigned           ADDR_WIDTH  = 3,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_RW      = 4,
  parameter logic [DATA_WIDTH-1:0] RW_RESET    = '0,
  parameter int unsigned           WAIT_CYCLES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         bus_req_i,
  input  logic                         bus_req_is_wr_i,
  input  logic [ADDR_WIDTH-1:0]        bus_addr_i,
  input  logic [DATA_WIDTH-1:0]        bus_wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]      bus_wr_biten_i,
  output logic                         bus_ready_o,
  output logic [DATA_WIDTH-1:0]        bus_rd_data_o,
  output logic                         bus_err_o,
  output logic [NUM_RW*DATA_WIDTH-1:0] hw_ctrl_o,
  input  logic [DATA_WIDTH-1:0]        hw_status_i,
  input  logic [DATA_WIDTH-1:0]        hw_irq_set_i,
  output logic                         irq_o
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(NUM_RW);
  localparam logic [ADDR_WIDTH-1:0] IRQ_IDX    = ADDR_WIDTH'(NUM_RW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd2;
`ifdef CSR_WAIT_EN
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] wait_q, wait_d;
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  is_wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NUM_BYTES-1:0]  biten_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_RW];
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] irq_clr;
  logic                  take;
  logic                  commit;

  assign take   = (state_q == ST_IDLE) && bus_req_i;
  assign commit = (state_q == ST_RESP) && is_wr_q && !err_q;

  // Decode the incoming request against current register contents (read data and error).
  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < int'(NUM_RW); i++) begin
      if (bus_addr_i == ADDR_WIDTH'(i)) begin
        rd_err = 1'b0;
        if (!bus_req_is_wr_i) rd_val = ctrl_q[i];
      end
    end
    if (bus_addr_i == STATUS_IDX) begin
      rd_err = bus_req_is_wr_i;
      if (!bus_req_is_wr_i) rd_val = hw_status_i;
    end
    if (bus_addr_i == IRQ_IDX) begin
      rd_err = 1'b0;
      if (!bus_req_is_wr_i) rd_val = pend_q;
    end
  end

  // Expand the captured byte enables into a bit mask.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      wr_mask[b*8 +: 8] = {8{biten_q[b]}};
    end
  end

  // Next values of the RW registers and IRQ_PEND; a hardware set beats a W1C clear.
  always_comb begin
    for (int i = 0; i < int'(NUM_RW); i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (commit && (addr_q == ADDR_WIDTH'(i))) begin
        ctrl_d[i] = (ctrl_q[i] & ~wr_mask) | (wdata_q & wr_mask);
      end
    end
    irq_clr = '0;
    if (commit && (addr_q == IRQ_IDX)) irq_clr = wdata_q & wr_mask;
    pend_d = (pend_q & ~irq_clr) | hw_irq_set_i;
  end

  // Request FSM: IDLE captures, optional WAIT stalls, RESP strobes ready once.
  always_comb begin
    state_d = state_q;
`ifdef CSR_WAIT_EN
    wait_d = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus_req_i) begin
`ifdef CSR_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            wait_d  = CW'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef CSR_WAIT_EN
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_RESP;
        else              wait_d  = wait_q - CW'(1);
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state plus the request/response capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      is_wr_q <= 1'b0;
      wdata_q <= '0;
      biten_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef CSR_WAIT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CSR_WAIT_EN
      wait_q  <= wait_d;
`endif
      if (take) begin
        addr_q  <= bus_addr_i;
        is_wr_q <= bus_req_is_wr_i;
        wdata_q <= bus_wr_data_i;
        biten_q <= bus_wr_biten_i;
        rdata_q <= rd_val;
        err_q   <= rd_err;
      end
    end
  end

  // Architectural registers: RW controls, pending interrupts and the registered irq.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_RW); i++) ctrl_q[i] <= RW_RESET;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_RW); i++) ctrl_q[i] <= ctrl_d[i];
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  for (genvar g = 0; g < int'(NUM_RW); g++) begin : g_ctrl
    assign hw_ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

  assign bus_ready_o   = (state_q == ST_RESP);
  assign bus_rd_data_o = bus_ready_o ? rdata_q : '0;
  assign bus_err_o     = bus_ready_o & err_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_csr_regblock.sv
// tb_csr_regblock: directed bench for csr_regblock with a transaction-level
// reference model that is compared against the DUT on every cycle.
module tb_csr_regblock;

  localparam int AW  = 3;
  localparam int DW  = 32;
  localparam int NRW = 4;
  localparam int WC  = 2;
`ifdef CSR_WAIT_EN
  localparam int WaitEff = WC;
`else
  localparam int WaitEff = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          busReq;
  logic          busIsWr;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busWrData;
  logic [3:0]    busBiten;
  logic          busReady;
  logic [DW-1:0] busRdData;
  logic          busErr;
  logic [NRW*DW-1:0] hwCtrl;
  logic [DW-1:0] hwStatus;
  logic [DW-1:0] hwIrqSet;
  logic          irq;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  csr_regblock #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .RW_RESET('0), .WAIT_CYCLES(WC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus_req_i(busReq), .bus_req_is_wr_i(busIsWr),
    .bus_addr_i(busAddr), .bus_wr_data_i(busWrData), .bus_wr_biten_i(busBiten),
    .bus_ready_o(busReady), .bus_rd_data_o(busRdData), .bus_err_o(busErr),
    .hw_ctrl_o(hwCtrl), .hw_status_i(hwStatus), .hw_irq_set_i(hwIrqSet), .irq_o(irq)
  );

  // Compare one value and keep the pass/total counts.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] beMask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference model: register contents as arrays, and the response as the
  // cycle number at which it is due (capture edge + wait cycles).
  logic [31:0] mCtrl [NRW];
  logic [31:0] mPend;
  logic        mIrq;
  bit          busy;
  bit          modelValid = 1'b0;
  int          edgeIdx = 0;
  int          capEdge;
  int          cAddr;
  bit          cWr;
  logic [31:0] cData;
  logic [3:0]  cBe;
  bit          expReady = 1'b0;
  logic [31:0] expRd;
  bit          expErr;
  bit          expRdChk;
  logic [31:0] mClr;
  bit          justDone;
  int          reqAddr;

  always @(posedge clk) begin
    edgeIdx++;
    if (rst) begin
      for (int i = 0; i < NRW; i++) mCtrl[i] = '0;
      mPend = '0;
      mIrq = 1'b0;
      busy = 1'b0;
      expReady = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      mClr = '0;
      justDone = 1'b0;
      if (busy && edgeIdx == capEdge + WaitEff + 1) begin
        if (cWr) begin
          if (cAddr < NRW) mCtrl[cAddr] = (mCtrl[cAddr] & ~beMask(cBe)) | (cData & beMask(cBe));
          else if (cAddr == NRW + 1) mClr = cData & beMask(cBe);
        end
        busy = 1'b0;
        justDone = 1'b1;
      end
      if (!busy && !justDone && busReq) begin
        reqAddr = int'(busAddr);
        cAddr = reqAddr; cWr = busIsWr; cData = busWrData; cBe = busBiten;
        expRdChk = 1'b1; expRd = '0; expErr = 1'b0;
        if (reqAddr < NRW) begin
          if (busIsWr) expRdChk = 1'b0; else expRd = mCtrl[reqAddr];
        end else if (reqAddr == NRW) begin
          if (busIsWr) begin expErr = 1'b1; expRdChk = 1'b0; end
          else expRd = hwStatus;
        end else if (reqAddr == NRW + 1) begin
          if (busIsWr) expRdChk = 1'b0; else expRd = mPend;
        end else begin
          expErr = 1'b1;
        end
        busy = 1'b1;
        capEdge = edgeIdx;
      end
      mIrq = |mPend;
      mPend = (mPend & ~mClr) | hwIrqSet;
      expReady = busy && (edgeIdx == capEdge + WaitEff);
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cycReady", 32'(busReady), 32'(expReady));
      if (expReady) begin
        checkOutput("cycErr", 32'(busErr), 32'(expErr));
        if (expRdChk) checkOutput("cycRdData", busRdData, expRd);
      end else begin
        checkOutput("cycRdIdle", busRdData, 32'h0);
        checkOutput("cycErrIdle", 32'(busErr), 32'h0);
      end
      checkOutput("cycIrq", 32'(irq), 32'(mIrq));
      for (int i = 0; i < NRW; i++) checkOutput("cycHwCtrl", hwCtrl[i*DW +: DW], mCtrl[i]);
    end
  end

  // One bus transaction: request held until ready; optional set pulse or reset during RESP.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [31:0] setInResp,
                               input bit rstInResp, output logic [31:0] rd, output logic err);
    int lat;
    bit seen;
    @(posedge clk); #1;
    busReq = 1'b1; busIsWr = wr; busAddr = a; busWrData = d; busBiten = be;
    lat = 0; seen = 1'b0; rd = '0; err = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busReady === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checkCount++;
      $display("[TB] FAIL txnTimeout: got no ready, expected ready within 30 cycles");
    end else begin
      checkOutput("latency", 32'(lat), 32'(2 + WaitEff));
      rd = busRdData;
      err = busErr;
      hwIrqSet = setInResp;
      if (rstInResp) rst = 1'b1;
    end
    @(posedge clk); #1;
    busReq = 1'b0;
    hwIrqSet = '0;
  endtask

  task automatic pulseIrqSet(input logic [31:0] v);
    @(posedge clk); #1; hwIrqSet = v;
    @(posedge clk); #1; hwIrqSet = '0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          readyCnt;

  initial begin
    rst = 1'b1; busReq = 1'b0; busIsWr = 1'b0; busAddr = '0; busWrData = '0;
    busBiten = '0; hwStatus = 32'h1234_5678; hwIrqSet = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", 32'(busReady), 32'h0);
    checkOutput("rstIrq", 32'(irq), 32'h0);
    for (int i = 0; i < NRW; i++) checkOutput("rstHwCtrl", hwCtrl[i*DW +: DW], 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("rstPendRd", rd, 32'h0);
    checkOutput("rstPendErr", 32'(err), 32'h0);

    // T2 byte-enabled write
    applyStimulus(1'b1, 3'd2, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, rd, err);
    checkOutput("bwErr", 32'(err), 32'h0);
    checkOutput("bwReadyDrop", 32'(busReady), 32'h0);
    checkOutput("bwHwCtrl2", hwCtrl[2*DW +: DW], 32'h00BB00DD);
    applyStimulus(1'b0, 3'd2, 32'h0, 4'hF, 32'h0, 1'b0, rd, err);
    checkOutput("bwReadBack", rd, 32'h00BB00DD);
    applyStimulus(1'b1, 3'd1, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, rd, err);
    checkOutput("zeroBeErr", 32'(err), 32'h0);
    checkOutput("zeroBeHold", hwCtrl[1*DW +: DW], 32'h0);

    // T3 status and error paths
    applyStimulus(1'b0, 3'd4, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("statusRd", rd, 32'h12345678);
    checkOutput("statusRdErr", 32'(err), 32'h0);
    applyStimulus(1'b1, 3'd4, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, rd, err);
    checkOutput("statusWrErr", 32'(err), 32'h1);
    for (int a = 6; a < 8; a++) begin
      for (int w = 0; w < 2; w++) begin
        applyStimulus(w[0], AW'(a), 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, rd, err);
        checkOutput("unmappedErr", 32'(err), 32'h1);
        checkOutput("unmappedRd", rd, 32'h0);
      end
    end

    // T4 W1C with a simultaneous set
    pulseIrqSet(32'h0000_0003);
    @(posedge clk); #1;
    checkOutput("irqAfterSet", 32'(irq), 32'h1);
    applyStimulus(1'b1, 3'd5, 32'h1, 4'hF, 32'h1, 1'b0, rd, err);
    applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("setWinsPend", rd, 32'h3);
    applyStimulus(1'b1, 3'd5, 32'h3, 4'hF, 32'h0, 1'b0, rd, err);
    checkOutput("irqBeforeDrop", 32'(irq), 32'h1);
    @(posedge clk); #1;
    checkOutput("irqCleared", 32'(irq), 32'h0);
    applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("pendCleared", rd, 32'h0);

    // T5 request held through its response, then reset during RESP
    @(posedge clk); #1;
    busReq = 1'b1; busIsWr = 1'b0; busAddr = 3'd2;
    readyCnt = 0;
    for (int c = 0; c < 2 + WaitEff; c++) begin
      @(negedge clk);
      if (busReady === 1'b1) readyCnt++;
    end
    @(posedge clk); #1;
    busReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busReady === 1'b1) readyCnt++;
    end
    checkOutput("heldOneReady", 32'(readyCnt), 32'h1);
    applyStimulus(1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, rd, err);
    checkOutput("rstRespReady", 32'(busReady), 32'h0);
    checkOutput("rstRespHwCtrl0", hwCtrl[0 +: DW], 32'h0);
    rst = 1'b0;

    // T6 back-to-back transactions; write then immediate read-back
    applyStimulus(1'b1, 3'd3, 32'h5A5A_C3C3, 4'hF, 32'h0, 1'b0, rd, err);
    applyStimulus(1'b0, 3'd3, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("b2bReadBack", rd, 32'h5A5AC3C3);
    applyStimulus(1'b1, 3'd0, 32'h1122_3344, 4'b1000, 32'h0, 1'b0, rd, err);
    applyStimulus(1'b0, 3'd0, 32'h0, 4'h0, 32'h0, 1'b0, rd, err);
    checkOutput("b2bTopByte", rd, 32'h11000000);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
